adder_seq: RTL
==============

# adder_seq

Parametrised, multi-cycle, slice-serial two's-complement adder/subtractor with a result accumulator and valid/ready handshakes on both sides. A WIDTH-bit operation is computed SLICE bits per clock, LSB slice first, through one registered carry. This trades latency for a short carry chain at large widths. It is the sequential successor of the 8-bit combinational adder and sits in the datapath wherever wide add, subtract or running-sum results are consumed through a stream handshake.

## Interface
- WIDTH, 32, operand/result width; must be an integer multiple of SLICE
- SLICE, 8, bits added per cycle; N = WIDTH/SLICE ≥ 1 cycles per operation
- i_clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_valid  in  1  input operation valid
- o_ready  out  1  block can accept an operation (high only in IDLE)
- i_a  in  WIDTH  operand A (ignored when i_acc=1)
- i_b  in  WIDTH  operand B
- i_cin  in  1  carry-in (ignored when i_sub=1)
- i_sub  in  1  1: compute A − B as A + ~B + 1
- i_acc  in  1  1: A operand is the accumulator instead of i_a
- i_clr  in  1  synchronous clear of accumulator
- o_valid  out  1  result valid
- i_ready  in  1  downstream accepts result
- o_sum  out  WIDTH  result
- o_carry  out  1  carry out of MSB (for subtract: 1 = no borrow)
- o_ovf  out  1  signed overflow
- o_acc  out  WIDTH  current accumulator value

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: o_ready=1. On i_valid&&o_ready:
  - latch opA = i_acc ? acc_q : i_a
  - latch opB = i_sub ? ~i_b : i_b
  - set c = i_sub ? 1 : i_cin, slice index k=0
  - → RUN
- RUN: each cycle adds slice k of opA, opB and c into sum slice k, registers the slice carry-out into c, then k++. After slice N−1 → DONE.
- DONE: o_valid=1. o_sum, o_carry and o_ovf are held stable until i_ready. On o_valid&&i_ready: acc_q ← o_sum, → IDLE.
- o_carry = final c. o_ovf = (opA[MSB]==opB[MSB]) && (sum[MSB]!=opA[MSB]), with opB taken after inversion.
- All arithmetic is modulo 2^WIDTH. No saturation.
- i_clr is honoured in any state: acc_q ← 0. If it coincides with the result handshake, clear wins. It does not affect an operation already latched.
- i_a, i_b, i_cin, i_sub and i_acc are sampled only at the accept edge. Changes afterwards have no effect.
- N=1 (SLICE=WIDTH) is legal: RUN lasts one cycle.

## Timing
- Reset values:
  - o_valid=0, o_sum=0, o_carry=0, o_ovf=0, o_acc=0
  - o_ready=1, because state is IDLE
  - internal k, c and operands are 0
- Latency: o_valid rises N cycles after the accept edge (N=4 at defaults).
- Minimum issue interval is N+2 cycles: N in RUN, ≥1 in DONE, 1 in IDLE. o_ready does not rise in the handshake cycle.
- Backpressure: DONE is held indefinitely while i_ready=0. Outputs must not glitch.
- o_sum, o_carry and o_ovf are registered. Their value outside DONE is the last result, or 0 after reset.
- Asserting reset in any state, including mid-RUN, immediately forces all reset values. The partial result is discarded and no o_valid is produced.

## Structure
- Package adder_pkg holds:
  - state enum typedef (IDLE/RUN/DONE)
  - default WIDTH/SLICE localparams
  - width function for the slice counter ($clog2(N), minimum 1)
- Sub-module adder_slice: combinational SLICE-bit adder with ports i_a, i_b, i_cin, o_sum, o_cout. It is instantiated once and muxed by k.
- Top-level adder_seq holds the FSM, operand/sum registers, accumulator and flag logic. Elaboration check: WIDTH % SLICE == 0.

## Test plan
All cases use defaults WIDTH=32, SLICE=8.
- Add 0x7FFFFFFF + 0x00000001, cin=0 → o_sum=0x80000000, o_carry=0, o_ovf=1; o_valid exactly 4 cycles after accept.
- Add 0x80000000 + 0x80000000 → o_sum=0x00000000, o_carry=1, o_ovf=1.
- Carry across all slice boundaries: 0x00FFFFFF + 0x00000000, cin=1 → o_sum=0x01000000, o_carry=0, o_ovf=0.
- Subtract 5 − 7, i_cin=1 (must be ignored) → o_sum=0xFFFFFFFE, o_carry=0, o_ovf=0. Subtract 7 − 5 → 0x00000002, o_carry=1.
- Accumulate:
  - i_clr, then three ops with i_acc=1 and B=10, 20, 30 → sums 10, 30, 60; o_acc=60.
  - Hold i_ready=0 for 5 cycles on the second op → o_sum stable at 30, o_ready=0 throughout.
- Reset mid-RUN at k=2 → o_valid=0, o_ready=1 and o_acc=0 immediately. The next op 3+4 returns 7.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and constants for the slice-serial adder/subtractor.
// Latency: n/a (types, parameters and an elaboration-time helper only).
// Backpressure: n/a.
package adder_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_SLICE = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Width of the slice counter for n slices; never narrower than one bit,
   // so a single-slice configuration still gets a legal vector.
   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/adder_slice.sv
// SLICE-bit combinational ripple adder used once per cycle by adder_seq.
// Latency: combinational, no state.
// Backpressure: none (pure function of its inputs).
//
// Ports:
//   i_a, i_b : slice operands
//   i_cin    : carry into the slice LSB
//   o_sum    : slice sum
//   o_cout   : carry out of the slice MSB
module adder_slice #(
   parameter int SLICE = 8
) (
   input  logic [SLICE-1:0] i_a,
   input  logic [SLICE-1:0] i_b,
   input  logic             i_cin,
   output logic [SLICE-1:0] o_sum,
   output logic             o_cout
);

   assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{SLICE{1'b0}}, i_cin};

endmodule

// File: rtl/adder_seq.sv
// Slice-serial WIDTH-bit add/subtract with result accumulator and valid/ready on both sides.
// Latency: o_valid rises N = WIDTH/SLICE cycles after the accept edge; issue interval >= N+2.
// Backpressure: result held in DONE, outputs stable, until i_ready; o_ready high only in IDLE.
//
// Ports:
//   i_clk, i_rst_n           : clock, asynchronous active-low reset
//   i_valid / o_ready        : operation handshake (i_a, i_b, i_cin, i_sub, i_acc sampled at accept)
//   i_acc                    : use the accumulator as operand A
//   i_clr                    : synchronous accumulator clear, any state, wins over result write-back
//   o_valid / i_ready        : result handshake
//   o_sum, o_carry, o_ovf    : registered result, carry out, signed overflow
//   o_acc                    : current accumulator
module adder_seq
   import adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SLICE = DEF_SLICE
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   input  logic             i_sub,
   input  logic             i_acc,
   input  logic             i_clr,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_carry,
   output logic             o_ovf,
   output logic [WIDTH-1:0] o_acc
);

   localparam int N  = WIDTH / SLICE;
   localparam int KW = cnt_w(N);
   localparam logic [KW-1:0] K_LAST = KW'(N - 1);

   if (WIDTH % SLICE != 0) begin : g_bad_width
      $error("adder_seq: WIDTH must be an integer multiple of SLICE");
   end

   state_e           state_q;
   logic             ready_q;
   logic             valid_q;
   logic [KW-1:0]    k_q;
   logic             c_q;
   logic [WIDTH-1:0] opa_q;
   logic [WIDTH-1:0] opb_q;
   logic [WIDTH-1:0] part_q;   // slices completed so far in the current operation
   logic [WIDTH-1:0] part_d;
   logic [WIDTH-1:0] sum_q;
   logic             carry_q;
   logic             ovf_q;
   logic [WIDTH-1:0] acc_q;

   logic [SLICE-1:0] sl_a;
   logic [SLICE-1:0] sl_b;
   logic [SLICE-1:0] sl_sum;
   logic             sl_cout;

   // One physical slice adder, fed by the slice selected by k.
   always_comb begin
      sl_a = opa_q[int'(k_q) * SLICE +: SLICE];
      sl_b = opb_q[int'(k_q) * SLICE +: SLICE];
   end

   adder_slice #(.SLICE(SLICE)) u_slice (
      .i_a    (sl_a),
      .i_b    (sl_b),
      .i_cin  (c_q),
      .o_sum  (sl_sum),
      .o_cout (sl_cout)
   );

   // The partial sum lives apart from sum_q so o_sum keeps the previous
   // result while a new operation is still running.
   always_comb begin
      part_d = part_q;
      part_d[int'(k_q) * SLICE +: SLICE] = sl_sum;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         k_q     <= '0;
         c_q     <= 1'b0;
         opa_q   <= '0;
         opb_q   <= '0;
         part_q  <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         acc_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (i_valid && ready_q) begin
                  opa_q   <= i_acc ? acc_q : i_a;
                  opb_q   <= i_sub ? ~i_b : i_b;
                  c_q     <= i_sub ? 1'b1 : i_cin;
                  k_q     <= '0;
                  part_q  <= '0;
                  ready_q <= 1'b0;
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               part_q <= part_d;
               c_q    <= sl_cout;
               if (k_q == K_LAST) begin
                  sum_q   <= part_d;
                  carry_q <= sl_cout;
                  // Overflow: operands agree in sign but the result does not.
                  ovf_q   <= (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                             (part_d[WIDTH-1] != opa_q[WIDTH-1]);
                  valid_q <= 1'b1;
                  state_q <= ST_DONE;
               end else begin
                  k_q <= k_q + 1'b1;
               end
            end
            ST_DONE: begin
               if (i_ready) begin
                  acc_q   <= sum_q;
                  valid_q <= 1'b0;
                  ready_q <= 1'b1;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               valid_q <= 1'b0;
               ready_q <= 1'b1;
               state_q <= ST_IDLE;
            end
         endcase
         // Placed last so a clear beats a same-cycle result write-back.
         if (i_clr) begin
            acc_q <= '0;
         end
      end
   end

   assign o_ready = ready_q;
   assign o_valid = valid_q;
   assign o_sum   = sum_q;
   assign o_carry = carry_q;
   assign o_ovf   = ovf_q;
   assign o_acc   = acc_q;

endmodule
